game_stat_ctrl: RTL and testbench
=================================

Name: game_stat_ctrl

Overview:
Game-statistics controller for the tank game. It sequences a game through idle, level load, play, level-clear and game-over. It accumulates per-player score and lives and tracks the enemy reserve from gameplay event strobes. It drives the score board's tank_left/level/score/lives inputs from double-buffered registers, so displayed values change only at frame boundaries.

Parameters:
ENEMY_TOTAL, 20, enemies per level loaded into reserve (1..63)
START_LIVES, 3, lives per player at game start (1..15)
MAX_LEVEL, 9, last level; clearing it ends the game with win_o=1 (1..15)
PTS_UNIT, 10, points per kill-type step; kill of type t scores (t+1)*PTS_UNIT
SCORE_MAX, 1999, score saturation value (<=2047)
CLEAR_FRAMES, 120, frame_start_i pulses spent in LEVEL_CLEAR

Ports:
clk_i  in  1  system clock (pixel clock domain)
rst_ni  in  1  asynchronous active-low reset
frame_start_i  in  1  one-cycle strobe at start of vertical blank
start_i  in  1  start/restart request, level sensitive, sampled in IDLE/GAME_OVER
enemy_spawn_i  in  1  strobe: one enemy leaves reserve and enters field
p1_kill_i, p2_kill_i  in  1 each  strobe: player destroyed an enemy
p1_kill_type_i, p2_kill_type_i  in  2 each  enemy type for the kill in the same cycle
p1_hit_i, p2_hit_i  in  1 each  strobe: player tank destroyed
base_hit_i  in  1  strobe: base destroyed
tank_left_o  out  6  displayed enemy reserve
level_o  out  4  displayed level
p1_score_o, p2_score_o  out  11 each  displayed scores
p1_lives_o, p2_lives_o  out  4 each  displayed lives
playing_o  out  1  state==PLAY (unbuffered)
level_clear_o  out  1  state==LEVEL_CLEAR (unbuffered)
game_over_o  out  1  state==GAME_OVER (unbuffered)
win_o  out  1  registered; set on GAME_OVER entry from MAX_LEVEL clear, cleared in LOAD

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; all shadow and display registers 0; alive count 0; out flags 0; win_o=0.
- Shadow regs (reserve, alive, level, scores, lives, p_out flags) update on event edges. Display outputs load from the pre-edge shadow values on any edge with frame_start_i=1, in any state. Events coincident with frame_start_i therefore appear one frame later. Latency from event strobe to output is 1 cycle to shadow, then the next frame_start_i edge.
- Event strobes are ignored outside PLAY.
- IDLE: start_i=1 -> LOAD with scores=0, lives=START_LIVES, p_out=0, level=0.
- LOAD (1 cycle): level=level+1, reserve=ENEMY_TOTAL, alive=0, win_o=0 -> PLAY.
- PLAY, per cycle, all simultaneous events are applied together:
  - spawn: if reserve>0 then reserve-1 and alive+1; if reserve==0 the spawn is ignored.
  - each kill: score += (type+1)*PTS_UNIT, saturating at SCORE_MAX. alive -= number of kills (0..2), saturating at 0. Spawn and kill in the same cycle net out.
  - hit: if lives>0 then lives-1; if lives==0 then p_out=1.
  - base_hit_i, or both p_out set after this cycle's update -> GAME_OVER (win_o=0). This has priority over level clear.
  - else if reserve==0 and alive==0 after this cycle's update -> LEVEL_CLEAR with frame counter=0.
- LEVEL_CLEAR: counts frame_start_i pulses. On the edge where count reaches CLEAR_FRAMES-1 with frame_start_i=1: if level==MAX_LEVEL then GAME_OVER with win_o=1, else LOAD.
- GAME_OVER: holds all values. start_i=1 -> same init as IDLE exit -> LOAD.
- The frame counter is 7 bits min, sized to CLEAR_FRAMES. Score addition uses a 12-bit intermediate before saturation.
- Reset mid-operation returns to IDLE immediately with all outputs 0.

Test Plan:
- Reset, start_i, then one frame_start_i -> level_o=1, tank_left_o=20, lives 3/3, scores 0, playing_o=1.
- PLAY: p1_kill type 3 and p2_kill type 0 in the same cycle, then frame_start_i -> p1_score_o=40, p2_score_o=10. Before the frame strobe, the outputs are unchanged.
- Set p1_score to 1990, then p1_kill type 1 -> p1_score_o=1999 (saturated).
- 20 spawns then 20 kills -> tank_left_o=0 and LEVEL_CLEAR. After 120 frame strobes -> LOAD, level_o=2, tank_left_o=20, scores retained.
- p1_hit ×4 and p2_hit ×4 -> lives 0/0, then GAME_OVER on the fourth hit of the second player. game_over_o=1, win_o=0, and further kill strobes leave scores unchanged.
- Spawn and kill same cycle with alive=0 -> alive stays 0 and reserve-1. Assert rst_ni low mid-PLAY -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/game_stat_ctrl.sv
// ============================================================================
// game_stat_ctrl : tank game sequencer with score/lives/reserve bookkeeping
//                  and frame-synchronous double-buffered score board outputs.
// Revision 1.0
// ============================================================================
`default_nettype none

module game_stat_ctrl #(
   parameter int ENEMY_TOTAL  = 20,
   parameter int START_LIVES  = 3,
   parameter int MAX_LEVEL    = 9,
   parameter int PTS_UNIT     = 10,
   parameter int SCORE_MAX    = 1999,
   parameter int CLEAR_FRAMES = 120
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        frame_start_i,
   input  logic        start_i,
   input  logic        enemy_spawn_i,
   input  logic        p1_kill_i,
   input  logic        p2_kill_i,
   input  logic [1:0]  p1_kill_type_i,
   input  logic [1:0]  p2_kill_type_i,
   input  logic        p1_hit_i,
   input  logic        p2_hit_i,
   input  logic        base_hit_i,
   output logic [5:0]  tank_left_o,
   output logic [3:0]  level_o,
   output logic [10:0] p1_score_o,
   output logic [10:0] p2_score_o,
   output logic [3:0]  p1_lives_o,
   output logic [3:0]  p2_lives_o,
   output logic        playing_o,
   output logic        level_clear_o,
   output logic        game_over_o,
   output logic        win_o
);

   localparam int FC_W = ($clog2(CLEAR_FRAMES) > 7) ? $clog2(CLEAR_FRAMES) : 7;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(CLEAR_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PLAY  = 3'd2,
      S_CLEAR = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [5:0]      reserve_q, reserve_d;
   logic [5:0]      alive_q, alive_d;
   logic [3:0]      level_q, level_d;
   logic [10:0]     p1_score_q, p1_score_d;
   logic [10:0]     p2_score_q, p2_score_d;
   logic [3:0]      p1_lives_q, p1_lives_d;
   logic [3:0]      p2_lives_q, p2_lives_d;
   logic            p1_out_q, p1_out_d;
   logic            p2_out_q, p2_out_d;
   logic            win_q, win_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;

   logic [5:0]      disp_tank_q, disp_tank_d;
   logic [3:0]      disp_level_q, disp_level_d;
   logic [10:0]     disp_s1_q, disp_s1_d;
   logic [10:0]     disp_s2_q, disp_s2_d;
   logic [3:0]      disp_l1_q, disp_l1_d;
   logic [3:0]      disp_l2_q, disp_l2_d;

   logic            spawn_ok;
   logic [1:0]      n_kill;
   logic [6:0]      alive_inc;

   // 12-bit sum keeps the carry visible so saturation is exact.
   function automatic logic [10:0] add_score(input logic [10:0] s, input logic [1:0] t);
      logic [11:0] sum;
      sum = {1'b0, s} + 12'((32'(t) + 32'd1) * PTS_UNIT);
      if (sum > 12'(SCORE_MAX)) add_score = 11'(SCORE_MAX);
      else                      add_score = sum[10:0];
   endfunction

   always_comb begin
      state_d    = state_q;
      reserve_d  = reserve_q;
      alive_d    = alive_q;
      level_d    = level_q;
      p1_score_d = p1_score_q;
      p2_score_d = p2_score_q;
      p1_lives_d = p1_lives_q;
      p2_lives_d = p2_lives_q;
      p1_out_d   = p1_out_q;
      p2_out_d   = p2_out_q;
      win_d      = win_q;
      fcnt_d     = fcnt_q;
      spawn_ok   = 1'b0;
      n_kill     = {1'b0, p1_kill_i} + {1'b0, p2_kill_i};
      alive_inc  = {1'b0, alive_q};

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_i) begin
               p1_score_d = '0;
               p2_score_d = '0;
               p1_lives_d = 4'(START_LIVES);
               p2_lives_d = 4'(START_LIVES);
               p1_out_d   = 1'b0;
               p2_out_d   = 1'b0;
               level_d    = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            level_d   = level_q + 4'd1;
            reserve_d = 6'(ENEMY_TOTAL);
            alive_d   = '0;
            win_d     = 1'b0;
            state_d   = S_PLAY;
         end
         S_PLAY: begin
            spawn_ok  = enemy_spawn_i && (reserve_q != 6'd0);
            reserve_d = reserve_q - {5'd0, spawn_ok};
            alive_inc = {1'b0, alive_q} + {6'd0, spawn_ok};
            alive_d   = (alive_inc >= {5'd0, n_kill}) ? 6'(alive_inc - {5'd0, n_kill}) : 6'd0;
            if (p1_kill_i) p1_score_d = add_score(p1_score_q, p1_kill_type_i);
            if (p2_kill_i) p2_score_d = add_score(p2_score_q, p2_kill_type_i);
            if (p1_hit_i) begin
               if (p1_lives_q != 4'd0) p1_lives_d = p1_lives_q - 4'd1;
               else                    p1_out_d   = 1'b1;
            end
            if (p2_hit_i) begin
               if (p2_lives_q != 4'd0) p2_lives_d = p2_lives_q - 4'd1;
               else                    p2_out_d   = 1'b1;
            end
            // Loss outranks a level clear decided in the same cycle.
            if (base_hit_i || (p1_out_d && p2_out_d)) begin
               win_d   = 1'b0;
               state_d = S_OVER;
            end else if ((reserve_d == 6'd0) && (alive_d == 6'd0)) begin
               fcnt_d  = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (frame_start_i) begin
               if (fcnt_q == FC_LAST) begin
                  if (level_q == 4'(MAX_LEVEL)) begin
                     win_d   = 1'b1;
                     state_d = S_OVER;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Display copies the pre-edge shadow so the board only changes per frame.
   always_comb begin
      disp_tank_d  = disp_tank_q;
      disp_level_d = disp_level_q;
      disp_s1_d    = disp_s1_q;
      disp_s2_d    = disp_s2_q;
      disp_l1_d    = disp_l1_q;
      disp_l2_d    = disp_l2_q;
      if (frame_start_i) begin
         disp_tank_d  = reserve_q;
         disp_level_d = level_q;
         disp_s1_d    = p1_score_q;
         disp_s2_d    = p2_score_q;
         disp_l1_d    = p1_lives_q;
         disp_l2_d    = p2_lives_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         reserve_q    <= '0;
         alive_q      <= '0;
         level_q      <= '0;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         p1_lives_q   <= '0;
         p2_lives_q   <= '0;
         p1_out_q     <= 1'b0;
         p2_out_q     <= 1'b0;
         win_q        <= 1'b0;
         fcnt_q       <= '0;
         disp_tank_q  <= '0;
         disp_level_q <= '0;
         disp_s1_q    <= '0;
         disp_s2_q    <= '0;
         disp_l1_q    <= '0;
         disp_l2_q    <= '0;
      end else begin
         state_q      <= state_d;
         reserve_q    <= reserve_d;
         alive_q      <= alive_d;
         level_q      <= level_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         p1_lives_q   <= p1_lives_d;
         p2_lives_q   <= p2_lives_d;
         p1_out_q     <= p1_out_d;
         p2_out_q     <= p2_out_d;
         win_q        <= win_d;
         fcnt_q       <= fcnt_d;
         disp_tank_q  <= disp_tank_d;
         disp_level_q <= disp_level_d;
         disp_s1_q    <= disp_s1_d;
         disp_s2_q    <= disp_s2_d;
         disp_l1_q    <= disp_l1_d;
         disp_l2_q    <= disp_l2_d;
      end
   end

   assign tank_left_o   = disp_tank_q;
   assign level_o       = disp_level_q;
   assign p1_score_o    = disp_s1_q;
   assign p2_score_o    = disp_s2_q;
   assign p1_lives_o    = disp_l1_q;
   assign p2_lives_o    = disp_l2_q;
   assign playing_o     = (state_q == S_PLAY);
   assign level_clear_o = (state_q == S_CLEAR);
   assign game_over_o   = (state_q == S_OVER);
   assign win_o         = win_q;

endmodule

`default_nettype wire

// File: tb/tb_game_stat_ctrl.sv
// ============================================================================
// tb_game_stat_ctrl : directed scoreboard bench for game_stat_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_game_stat_ctrl;

   localparam int C_ENEMY = 20;
   localparam int C_LIVES = 3;
   localparam int C_PTS   = 10;
   localparam int C_SMAX  = 1999;
   localparam int C_CLEAR = 120;
   localparam int C_MAXL  = 9;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        frame_start_i = 1'b0, start_i = 1'b0, enemy_spawn_i = 1'b0;
   logic        p1_kill_i = 1'b0, p2_kill_i = 1'b0;
   logic [1:0]  p1_kill_type_i = 2'd0, p2_kill_type_i = 2'd0;
   logic        p1_hit_i = 1'b0, p2_hit_i = 1'b0, base_hit_i = 1'b0;
   logic [5:0]  tank_left_o;
   logic [3:0]  level_o;
   logic [10:0] p1_score_o, p2_score_o;
   logic [3:0]  p1_lives_o, p2_lives_o;
   logic        playing_o, level_clear_o, game_over_o, win_o;

   game_stat_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i), .start_i(start_i),
      .enemy_spawn_i(enemy_spawn_i), .p1_kill_i(p1_kill_i), .p2_kill_i(p2_kill_i),
      .p1_kill_type_i(p1_kill_type_i), .p2_kill_type_i(p2_kill_type_i),
      .p1_hit_i(p1_hit_i), .p2_hit_i(p2_hit_i), .base_hit_i(base_hit_i),
      .tank_left_o(tank_left_o), .level_o(level_o),
      .p1_score_o(p1_score_o), .p2_score_o(p2_score_o),
      .p1_lives_o(p1_lives_o), .p2_lives_o(p2_lives_o),
      .playing_o(playing_o), .level_clear_o(level_clear_o),
      .game_over_o(game_over_o), .win_o(win_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int tank; int level; int s1; int s2; int l1; int l2;
   } disp_t;

   disp_t exp_q[$];
   int    n_err = 0;
   int    n_chk = 0;

   int m_res = 0, m_level = 0, m_s1 = 0, m_s2 = 0, m_l1 = 0, m_l2 = 0;
   bit m_play = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v > C_SMAX) ? C_SMAX : v;
   endfunction

   task automatic ev(input bit sp, input bit k1, input int t1, input bit k2, input int t2,
                     input bit h1, input bit h2);
      enemy_spawn_i = sp; p1_kill_i = k1; p2_kill_i = k2;
      p1_kill_type_i = 2'(t1); p2_kill_type_i = 2'(t2);
      p1_hit_i = h1; p2_hit_i = h2;
      cyc();
      enemy_spawn_i = 0; p1_kill_i = 0; p2_kill_i = 0; p1_hit_i = 0; p2_hit_i = 0;
      if (m_play) begin
         if (sp && m_res > 0) m_res--;
         if (k1) m_s1 = sat(m_s1 + (t1 + 1) * C_PTS);
         if (k2) m_s2 = sat(m_s2 + (t2 + 1) * C_PTS);
         if (h1 && m_l1 > 0) m_l1--;
         if (h2 && m_l2 > 0) m_l2--;
      end
   endtask

   task automatic frame();
      disp_t e;
      exp_q.push_back('{m_res, m_level, m_s1, m_s2, m_l1, m_l2});
      frame_start_i = 1;
      cyc();
      frame_start_i = 0;
      e = exp_q.pop_front();
      chk("tank_left", 32'(tank_left_o), e.tank);
      chk("level", 32'(level_o), e.level);
      chk("p1_score", 32'(p1_score_o), e.s1);
      chk("p2_score", 32'(p2_score_o), e.s2);
      chk("p1_lives", 32'(p1_lives_o), e.l1);
      chk("p2_lives", 32'(p2_lives_o), e.l2);
   endtask

   task automatic start_game();
      start_i = 1;
      cyc();
      start_i = 0;
      m_s1 = 0; m_s2 = 0; m_l1 = C_LIVES; m_l2 = C_LIVES; m_level = 0;
      cyc();
      m_level = 1; m_res = C_ENEMY; m_play = 1;
   endtask

   task automatic clear_frames();
      for (int f = 0; f < C_CLEAR - 1; f++) frame();
      chk("still_clear", 32'(level_clear_o), 1);
      frame();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tank"}, 32'(tank_left_o), 0);
      chk({tag, "_level"}, 32'(level_o), 0);
      chk({tag, "_s1"}, 32'(p1_score_o), 0);
      chk({tag, "_s2"}, 32'(p2_score_o), 0);
      chk({tag, "_l1"}, 32'(p1_lives_o), 0);
      chk({tag, "_l2"}, 32'(p2_lives_o), 0);
      chk({tag, "_playing"}, 32'(playing_o), 0);
      chk({tag, "_clear"}, 32'(level_clear_o), 0);
      chk({tag, "_over"}, 32'(game_over_o), 0);
      chk({tag, "_win"}, 32'(win_o), 0);
   endtask

   initial begin
      repeat (3) cyc();
      chk_all_zero("reset");
      rst_ni = 1;
      cyc();

      // Start and first frame shows level 1.
      start_game();
      chk("playing_l1", 32'(playing_o), 1);
      frame();

      // Simultaneous kills; display holds until the next frame.
      ev(0, 1, 3, 1, 0, 0, 0);
      chk("s1_before_frame", 32'(p1_score_o), 0);
      chk("s2_before_frame", 32'(p2_score_o), 0);
      frame();

      // Drive p1 to 1990, then saturate.
      for (int i = 0; i < 48; i++) ev(0, 1, 3, 0, 0, 0, 0);
      ev(0, 1, 2, 0, 0, 0, 0);
      frame();
      ev(0, 1, 1, 0, 0, 0, 0);
      frame();

      // Level 1: 20 spawns then 20 kills.
      for (int i = 0; i < C_ENEMY; i++) ev(1, 0, 0, 0, 0, 0, 0);
      frame();
      for (int i = 0; i < C_ENEMY - 1; i++) ev(0, 0, 0, 1, 0, 0, 0);
      chk("clear_not_yet", 32'(level_clear_o), 0);
      ev(0, 0, 0, 1, 0, 0, 0);
      chk("clear_l1", 32'(level_clear_o), 1);
      chk("not_playing_clear", 32'(playing_o), 0);
      m_play = 0;
      clear_frames();
      chk("load_clear_off", 32'(level_clear_o), 0);
      chk("load_not_playing", 32'(playing_o), 0);
      cyc();
      m_level = 2; m_res = C_ENEMY; m_play = 1;
      chk("playing_l2", 32'(playing_o), 1);
      frame();

      // Level 2: spawn+kill with no live enemies keeps alive at zero.
      ev(1, 1, 0, 0, 0, 0, 0);
      frame();
      for (int i = 0; i < C_ENEMY - 1; i++) ev(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < C_ENEMY - 2; i++) ev(0, 0, 0, 1, 2, 0, 0);
      chk("clear_l2_not_yet", 32'(level_clear_o), 0);
      ev(0, 0, 0, 1, 2, 0, 0);
      chk("clear_l2", 32'(level_clear_o), 1);
      m_play = 0;
      clear_frames();
      cyc();
      m_level = 3; m_res = C_ENEMY; m_play = 1;
      frame();

      // Level 3: lose all lives on both players.
      for (int i = 0; i < 4; i++) ev(0, 0, 0, 0, 0, 1, 0);
      chk("p1_out_still_playing", 32'(playing_o), 1);
      for (int i = 0; i < 3; i++) ev(0, 0, 0, 0, 0, 0, 1);
      chk("p2_zero_still_playing", 32'(playing_o), 1);
      ev(0, 0, 0, 0, 0, 0, 1);
      chk("game_over_hits", 32'(game_over_o), 1);
      chk("win_after_loss", 32'(win_o), 0);
      m_play = 0;
      ev(1, 1, 3, 1, 3, 0, 0);
      frame();

      // Restart and clear every level to reach a win.
      start_game();
      chk("restart_playing", 32'(playing_o), 1);
      chk("restart_win", 32'(win_o), 0);
      frame();
      for (int lv = 1; lv <= C_MAXL; lv++) begin
         for (int i = 0; i < C_ENEMY; i++) ev(1, 1, 1, 0, 0, 0, 0);
         chk("clear_loop", 32'(level_clear_o), 1);
         m_play = 0;
         clear_frames();
         if (lv < C_MAXL) begin
            cyc();
            m_level = lv + 1; m_res = C_ENEMY; m_play = 1;
            chk("playing_loop", 32'(playing_o), 1);
         end
      end
      chk("win_over", 32'(game_over_o), 1);
      chk("win_flag", 32'(win_o), 1);
      frame();

      // LOAD clears win; then reset mid-play.
      start_game();
      chk("win_cleared", 32'(win_o), 0);
      chk("playing_again", 32'(playing_o), 1);
      frame();
      for (int i = 0; i < 3; i++) ev(1, 0, 0, 0, 0, 0, 0);
      #3;
      rst_ni = 0;
      #1;
      chk_all_zero("midreset");
      cyc();
      rst_ni = 1;
      cyc();
      chk("idle_after_reset", 32'(playing_o), 0);
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
